// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice:
// fetch FSM states, jump opcodes, redirect control bundle and default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    ERROR = 2'd2
  } fetch_state_e;

  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [5:0]  OP_JAL           = 6'b000011;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic branch;
    logic nbranch;
    logic zero;
    logic jmp;
    logic jal;
    logic jr;
  } redirect_t;

  // Pseudo-direct jump target: upper nibble of PC+4, 26-bit index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] instr_index);
    return {pc4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Combinational next-PC selection for the held instruction, plus the
// misaligned register-jump flag.
module npc_sel
  import mips_pkg::*;
(
  input  logic [31:0] opcplus4_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] sign_extend_i,
  input  logic [31:0] read_data_1_i,
  input  redirect_t   redirect_i,
  output logic [31:0] next_pc_o,
  output logic        jr_misalign_o
);

  logic        branch_taken;
  logic [31:0] branch_target;

  assign branch_taken  = (redirect_i.branch  &  redirect_i.zero) |
                         (redirect_i.nbranch & ~redirect_i.zero);
  assign branch_target = opcplus4_i + (sign_extend_i << 2);

  // Register jump wins over jumps, jumps win over branches.
  always_comb begin
    if (redirect_i.jr) begin
      next_pc_o = {read_data_1_i[31:2], 2'b00};
    end else if (redirect_i.jmp | redirect_i.jal) begin
      next_pc_o = jump_target(opcplus4_i, instr_index_i);
    end else if (branch_taken) begin
      next_pc_o = branch_target;
    end else begin
      next_pc_o = opcplus4_i;
    end
  end

  assign jr_misalign_o = redirect_i.jr & (|read_data_1_i[1:0]);

endmodule

// File: rtl/ifetch32_hs.sv
// Handshaked 32-bit instruction fetch unit: requests a word at PC, holds it
// for the decoder until advanced, redirects PC, and traps on memory timeout.
module ifetch32_hs
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] opcplus4,
  output logic        inst_valid,
  input  logic        advance,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Zero,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  input  logic [31:0] Sign_extend,
  input  logic [31:0] read_data_1,
  output logic        misalign,
  output logic        imem_err
);

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  fetch_state_e      state_q,    state_d;
  logic [31:0]       pc_q,       pc_d;
  logic [31:0]       instr_q,    instr_d;
  logic [31:0]       opc4_q,     opc4_d;
  logic              valid_q,    valid_d;
  logic              misalign_q, misalign_d;
  logic              err_q,      err_d;
  logic [WAIT_W-1:0] wait_q,     wait_d;

  logic [31:0] next_pc;
  logic        jr_misalign;
  redirect_t   redirect;

  assign redirect = '{branch:  Branch,  nbranch: nBranch, zero: Zero,
                      jmp:     Jmp,     jal:     Jal,     jr:   Jr};

  npc_sel u_npc_sel (
    .opcplus4_i    (opc4_q),
    .instr_index_i (instr_q[25:0]),
    .sign_extend_i (Sign_extend),
    .read_data_1_i (read_data_1),
    .redirect_i    (redirect),
    .next_pc_o     (next_pc),
    .jr_misalign_o (jr_misalign)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    opc4_d     = opc4_q;
    valid_d    = valid_q;
    wait_d     = wait_q;
    misalign_d = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          opc4_d  = pc_q + 32'd4;
          valid_d = 1'b1;
          wait_d  = '0;
          state_d = VALID;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      VALID: begin
        if (advance) begin
          pc_d       = next_pc;
          valid_d    = 1'b0;
          wait_d     = '0;
          misalign_d = jr_misalign;
          state_d    = FETCH;
        end
      end
      ERROR: begin
        // Frozen until reset; inputs deliberately ignored.
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch only.
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      opc4_q     <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      opc4_q     <= opc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  // Request is gated by reset so memory never sees a request while held in reset.
  assign imem_req    = rst & (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign opcplus4    = opc4_q;
  assign inst_valid  = valid_q;
  assign misalign    = misalign_q;
  assign imem_err    = err_q;

endmodule

// File: tb/tb_ifetch32_hs.sv
// Directed self-checking bench for ifetch32_hs: reset, fetch handshake,
// PC redirects, wrap-around, misaligned Jr, timeout and reset-abandon cases.
module tb_ifetch32_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] opcplus4;
  logic        inst_valid;
  logic        advance;
  logic        Branch, nBranch, Zero, Jmp, Jal, Jr;
  logic [31:0] Sign_extend;
  logic [31:0] read_data_1;
  logic        misalign;
  logic        imem_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifetch32_hs #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .opcplus4    (opcplus4),
    .inst_valid  (inst_valid),
    .advance     (advance),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Zero        (Zero),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jr          (Jr),
    .Sign_extend (Sign_extend),
    .read_data_1 (read_data_1),
    .misalign    (misalign),
    .imem_err    (imem_err)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    imem_ack    = 1'b0;
    advance     = 1'b0;
    Branch      = 1'b0;
    nBranch     = 1'b0;
    Zero        = 1'b0;
    Jmp         = 1'b0;
    Jal         = 1'b0;
    Jr          = 1'b0;
    Sign_extend = 32'h0;
    read_data_1 = 32'h0;
  endtask

  task automatic fetch_word(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    imem_rdata = 32'h0;
    clear_ctrl();

    // Reset state
    step();
    step();
    check("rst_req_low",     {31'b0, imem_req},   32'd0);
    check("rst_inst_valid",  {31'b0, inst_valid}, 32'd0);
    check("rst_imem_err",    {31'b0, imem_err},   32'd0);
    check("rst_misalign",    {31'b0, misalign},   32'd0);
    check("rst_instruction", Instruction,         32'h0);
    check("rst_opcplus4",    opcplus4,            32'h0);

    // First fetch, ack in first FETCH cycle
    rst = 1'b1;
    #1;
    check("fetch0_req",  {31'b0, imem_req}, 32'd1);
    check("fetch0_addr", imem_addr,         32'h0);
    fetch_word(32'h0043_3820);
    check("fetch0_instr", Instruction,         32'h0043_3820);
    check("fetch0_pc4",   opcplus4,            32'h4);
    check("fetch0_valid", {31'b0, inst_valid}, 32'd1);
    check("valid_req",    {31'b0, imem_req},   32'd0);

    // Ack during VALID is ignored
    fetch_word(32'hDEAD_BEEF);
    check("valid_ack_ignored", Instruction,         32'h0043_3820);
    check("valid_still",       {31'b0, inst_valid}, 32'd1);

    // Sequential advance
    advance = 1'b1;
    step();
    clear_ctrl();
    check("seq_addr",  imem_addr,           32'h4);
    check("seq_valid", {31'b0, inst_valid}, 32'd0);

    // Advance and redirect inputs ignored in FETCH
    advance     = 1'b1;
    Jr          = 1'b1;
    read_data_1 = 32'h40;
    step();
    clear_ctrl();
    check("fetch_adv_ignored", imem_addr,         32'h4);
    check("fetch_req_held",    {31'b0, imem_req}, 32'd1);

    // Taken backward branch: 8 + (-1 << 2) = 4
    fetch_word(32'h1000_FFFF);
    check("br_pc4", opcplus4, 32'h8);
    advance     = 1'b1;
    Branch      = 1'b1;
    Zero        = 1'b1;
    Sign_extend = 32'hFFFF_FFFF;
    step();
    clear_ctrl();
    check("beq_taken_addr", imem_addr, 32'h4);

    // bne with Zero=1 is not taken
    fetch_word(32'h1400_FFFF);
    advance     = 1'b1;
    nBranch     = 1'b1;
    Zero        = 1'b1;
    Sign_extend = 32'hFFFF_FFFF;
    step();
    clear_ctrl();
    check("bne_not_taken_addr", imem_addr, 32'h8);

    // Jr to 0x1000_0014, then JAL from there
    fetch_word(32'h0000_0000);
    advance     = 1'b1;
    Jr          = 1'b1;
    read_data_1 = 32'h1000_0014;
    step();
    clear_ctrl();
    check("jr_addr",        imem_addr,         32'h1000_0014);
    check("jr_aligned_mis", {31'b0, misalign}, 32'd0);
    fetch_word(32'h0C00_0010);
    check("jal_pc4", opcplus4, 32'h1000_0018);
    advance = 1'b1;
    Jal     = 1'b1;
    step();
    clear_ctrl();
    check("jal_addr", imem_addr, 32'h1000_0040);

    // Misaligned Jr with Jal also asserted: Jr wins, target word-aligned
    fetch_word(32'h0000_0000);
    advance     = 1'b1;
    Jr          = 1'b1;
    Jal         = 1'b1;
    read_data_1 = 32'h0000_0102;
    step();
    clear_ctrl();
    check("jr_mis_addr",  imem_addr,         32'h0000_0100);
    check("misalign_hi",  {31'b0, misalign}, 32'd1);
    step();
    check("misalign_lo",  {31'b0, misalign}, 32'd0);
    check("mis_addr_hold", imem_addr,        32'h0000_0100);

    // Wrap-around from 0xFFFF_FFFC
    fetch_word(32'h0000_0000);
    advance     = 1'b1;
    Jr          = 1'b1;
    read_data_1 = 32'hFFFF_FFFC;
    step();
    clear_ctrl();
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_word(32'h0000_0000);
    check("wrap_pc4", opcplus4, 32'h0);
    advance = 1'b1;
    step();
    clear_ctrl();
    check("wrap_addr", imem_addr, 32'h0);

    // Reset asserted in VALID at PC=0x20 with coincident ack
    fetch_word(32'h0000_0000);
    advance     = 1'b1;
    Jr          = 1'b1;
    read_data_1 = 32'h20;
    step();
    clear_ctrl();
    fetch_word(32'h1234_5678);
    check("pc20_addr",  imem_addr,           32'h20);
    check("pc20_valid", {31'b0, inst_valid}, 32'd1);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_5555;
    step();
    imem_ack = 1'b0;
    check("rstv_valid", {31'b0, inst_valid}, 32'd0);
    check("rstv_instr", Instruction,         32'h0);
    check("rstv_req",   {31'b0, imem_req},   32'd0);
    rst = 1'b1;
    #1;
    check("rel_addr", imem_addr,         32'h0);
    check("rel_req",  {31'b0, imem_req}, 32'd1);

    // Timeout: 15 edges without ack stay in FETCH, the 16th traps
    repeat (15) step();
    check("to15_err", {31'b0, imem_err}, 32'd0);
    check("to15_req", {31'b0, imem_req}, 32'd1);
    step();
    check("to16_err",   {31'b0, imem_err},   32'd1);
    check("to16_req",   {31'b0, imem_req},   32'd0);
    check("to16_valid", {31'b0, inst_valid}, 32'd0);

    // ERROR ignores ack and advance
    imem_ack    = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    advance     = 1'b1;
    Jr          = 1'b1;
    read_data_1 = 32'h81;
    repeat (3) step();
    check("err_sticky", {31'b0, imem_err},   32'd1);
    check("err_addr",   imem_addr,           32'h0);
    check("err_valid",  {31'b0, inst_valid}, 32'd0);
    check("err_instr",  Instruction,         32'h0);
    check("err_mis",    {31'b0, misalign},   32'd0);
    check("err_req",    {31'b0, imem_req},   32'd0);

    // Only reset clears ERROR
    clear_ctrl();
    rst = 1'b0;
    step();
    check("err_cleared", {31'b0, imem_err}, 32'd0);
    rst = 1'b1;
    #1;
    check("post_err_req", {31'b0, imem_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
